uart_rx_fifo: RTL and testbench

//  Sits directly downstream of the UART receiver. Captures each received word
//  on the rising edge of the receiver's data_ready level.

---
 rtl/uart_rx_fifo_pkg.sv | 15 +
 rtl/uart_edge_detect.sv | 19 +
 rtl/uart_rx_fifo.sv | 90 +++++++++
 tb/tb_uart_rx_fifo.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and helpers used by the receiver-side FIFO.
// The receiver and the future transmitter use the same definitions.
package uart_rx_fifo_pkg;

   localparam int UART_DATA_WIDTH   = 8;
   localparam int UART_DELAY_FRAMES = 2812;
   localparam int ERR_COUNT_WIDTH   = 8;

   function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc(
      input logic [ERR_COUNT_WIDTH-1:0] val
   );
      return (&val) ? val : val + 1'b1;
   endfunction

endpackage

// File: rtl/uart_edge_detect.sv
// Rising-edge detector for a receiver level flag.
// The history register resets high, so a level that is already high at reset release does not count as an edge.
module uart_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic rise
);

   logic r_hist;

   always_ff @(posedge clk) begin
      if (rst) r_hist <= 1'b1;
      else     r_hist <= in;
   end

   assign rise = in & ~r_hist;

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures UART receiver words on data_ready rising edges into a first-word-fall-through FIFO.
// The FIFO drains over valid/ready, and the block also keeps a saturating count of framing-error edges.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = UART_DATA_WIDTH,
   parameter  int DEPTH      = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_data_ready,
   input  logic                  rx_comm_err,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  overflow,
   output logic [7:0]            err_count
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic [7:0]            r_err_count;

   logic w_push_req;
   logic w_err_edge;
   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   uart_edge_detect u_rdy_edge (
      .clk  (clk),
      .rst  (rst),
      .in   (rx_data_ready),
      .rise (w_push_req)
   );

   uart_edge_detect u_err_edge (
      .clk  (clk),
      .rst  (rst),
      .in   (rx_comm_err),
      .rise (w_err_edge)
   );

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
   assign w_pop   = ~w_empty & out_ready;
   // At full a push is still accepted when the head leaves in the same cycle.
   assign w_push  = w_push_req & (~w_full | w_pop);

   always_ff @(posedge clk) begin
      if (!rst && w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
         if (w_err_edge) r_err_count <= sat_inc(r_err_count);
      end
   end

   assign out_data  = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
   assign out_valid = ~w_empty;
   assign count     = r_count;
   assign full      = w_full;
   assign overflow  = r_overflow;
   assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scenarios and a randomized run for uart_rx_fifo, checked against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] rx_data = '0;
   logic          rx_data_ready = 1'b0;
   logic          rx_comm_err = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic [4:0]    count;
   logic          full;
   logic          overflow;
   logic [7:0]    err_count;

   uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_data_ready (rx_data_ready),
      .rx_comm_err   (rx_comm_err),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .count         (count),
      .full          (full),
      .overflow      (overflow),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] m_q[$];
   bit            m_prev_rdy = 1'b1;
   bit            m_prev_err = 1'b1;
   bit            m_ovf = 1'b0;
   int            m_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model over the edge, compare just after it.
   task automatic step(input bit r, input bit rdy, input logic [DW-1:0] d,
                       input bit err, input bit ordy);
      bit push;
      bit pop;
      rst = r; rx_data_ready = rdy; rx_data = d; rx_comm_err = err; out_ready = ordy;
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_prev_rdy = 1'b1;
         m_prev_err = 1'b1;
         m_ovf = 1'b0;
         m_err = 0;
      end else begin
         push = rdy && !m_prev_rdy;
         pop  = ordy && (m_q.size() > 0);
         if (err && !m_prev_err && m_err < 255) m_err++;
         m_prev_rdy = rdy;
         m_prev_err = err;
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      chk("count", 32'(count), 32'(m_q.size()));
      chk("full", 32'(full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("err_count", 32'(err_count), 32'(m_err));
      if (m_q.size() != 0) chk("out_data", 32'(out_data), 32'(m_q[0]));
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic push_word(input logic [DW-1:0] d, input bit ordy);
      step(1'b0, 1'b1, d, 1'b0, ordy);
      step(1'b0, 1'b0, d, 1'b0, ordy);
   endtask

   initial begin
      int cyc;
      @(negedge clk);
      do_reset();
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_valid", 32'(out_valid), 32'd0);

      // Single word held high for 100 cycles pushes once.
      step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_data", 32'(out_data), 32'hA5);
      for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      chk("single_count", 32'(count), 32'd1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("single_drained", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Ordering and pointer wrap with slow draining.
      cyc = 0;
      for (int w = 0; w < 40; w++) begin
         step(1'b0, 1'b1, 8'(w), 1'b0, (cyc % 3) == 0); cyc++;
         step(1'b0, 1'b0, 8'(w), 1'b0, (cyc % 3) == 0); cyc++;
      end
      for (int i = 0; i < 60; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("order_ovf", 32'(overflow), 32'd0);
      chk("order_empty", 32'(count), 32'd0);

      // Overflow drops the 17th word.
      for (int w = 0; w < 17; w++) push_word(8'h10 + 8'(w), 1'b0);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Push and pop in the same cycle at full.
      do_reset();
      for (int w = 0; w < 16; w++) push_word(8'(w), 1'b0);
      step(1'b0, 1'b1, 8'h55, 1'b0, 1'b1);
      chk("simul_count", 32'(count), 32'd16);
      chk("simul_ovf", 32'(overflow), 32'd0);
      step(1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      chk("simul_last", 32'(out_data), 32'h55);
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);

      // Level high across reset release is not an edge; reset flushes.
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("rst_nopush", 32'(count), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int w = 0; w < 5; w++) push_word(8'hC0 + 8'(w), 1'b0);
      chk("rst_pre", 32'(count), 32'd5);
      step(1'b1, 1'b0, '0, 1'b0, 1'b0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);

      // Error edges: a long level counts once, then saturation.
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("err_level", 32'(err_count), 32'd1);
      for (int i = 0; i < 300; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         step(1'b0, 1'b0, '0, 1'b0, 1'b0);
      end
      chk("err_sat", 32'(err_count), 32'hFF);
      chk("err_nopush", 32'(count), 32'd0);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 399) == 0),
              ($urandom_range(0, 2) != 0) ? ~rx_data_ready : rx_data_ready,
              8'($urandom),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
